mul_acc_sgn: RTL and testbench

MUL_ACC_SGN -- requirements
Module: mul_acc_sgn

---
 rtl/mul_acc_pkg.sv | 19 +
 rtl/Add.sv | 25 ++
 rtl/acc_add_sat.sv | 36 +++
 rtl/mul_acc_sgn.sv | 125 ++++++++++++
 tb/tb_mul_acc_sgn.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_acc_pkg.sv
// Shared types and helpers for the signed multiply-accumulate slice.
package mul_acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_e;

  // Saturation limit for a two's-complement value of the given width.
  // The result is truncated by the caller.
  function automatic logic [63:0] sat_limit(input int width, input logic neg);
    if (neg) begin
      return {64{1'b1}} << (width - 1);
    end
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/Add.sv
// Codebase adder: speed=0 builds a ripple-carry chain, any other value a plain '+'.
module Add #(
  parameter int width = 8,
  parameter int speed = 0
) (
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  output logic [width-1:0] sum_o
);

  if (speed == 0) begin : g_ripple
    always_comb begin : p_ripple
      logic carry;
      carry = 1'b0;
      sum_o = '0;
      for (int i = 0; i < width; i++) begin
        sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
        carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
      end
    end
  end else begin : g_fast
    assign sum_o = a_i + b_i;
  end

endmodule

// File: rtl/acc_add_sat.sv
// Combinational accumulate step: signed add, overflow flag and, when
// MUL_ACC_SAT_EN is defined, clamping to the signed range of widthA.
module acc_add_sat
  import mul_acc_pkg::*;
#(
  parameter int widthA = 24,
  parameter int speed  = 0
) (
  input  logic [widthA-1:0] acc_i,
  input  logic [widthA-1:0] prod_i,
  output logic [widthA-1:0] sum_o,
  output logic              ovf_o
);

  logic [widthA-1:0] raw_sum;

  Add #(
    .width(widthA),
    .speed(speed)
  ) u_add (
    .a_i  (acc_i),
    .b_i  (prod_i),
    .sum_o(raw_sum)
  );

  // Overflow only when operands share a sign that the sum does not.
  assign ovf_o = (acc_i[widthA-1] == prod_i[widthA-1]) &&
                 (raw_sum[widthA-1] != acc_i[widthA-1]);

`ifdef MUL_ACC_SAT_EN
  assign sum_o = ovf_o ? widthA'(sat_limit(widthA, acc_i[widthA-1])) : raw_sum;
`else
  assign sum_o = raw_sum;
`endif

endmodule

// File: rtl/mul_acc_sgn.sv
// Signed product accumulator with valid/ready handshakes and per-packet
// overflow flag. MUL_ACC_SAT_EN switches overflow from wrap to saturation.
module mul_acc_sgn
  import mul_acc_pkg::*;
#(
  parameter int widthP = 16,
  parameter int widthA = 24,
  parameter int widthC = 8,
  parameter int speed  = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [widthP-1:0] in_prod_i,
  input  logic              in_last_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [widthA-1:0] out_acc_o,
  output logic [widthC-1:0] out_cnt_o,
  output logic              out_ovf_o
);

  if (widthA < widthP) begin : g_width_check
    $error("mul_acc_sgn: widthA must be >= widthP");
  end

  state_e                   state_q, state_d;
  logic [widthA-1:0]        acc_q, acc_d;
  logic [widthC-1:0]        cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [widthP-1:0] prod_s;
  logic [widthA-1:0]        prod_ext;
  logic [widthA-1:0]        sum;
  logic                     add_ovf;
  logic                     accept;

  assign prod_s   = in_prod_i;
  assign prod_ext = widthA'(prod_s);
  assign accept   = in_valid_i & in_ready_q;

  acc_add_sat #(
    .widthA(widthA),
    .speed (speed)
  ) u_add_sat (
    .acc_i (acc_q),
    .prod_i(prod_ext),
    .sum_o (sum),
    .ovf_o (add_ovf)
  );

  // Abort wins over both handshakes; consuming a result never accepts input.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clr_i) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d   = prod_ext;
            cnt_d   = widthC'(1);
            ovf_d   = 1'b0;
            state_d = in_last_i ? DONE : ACC;
          end
        end
        ACC: begin
          if (accept) begin
            acc_d = sum;
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + widthC'(1);
            ovf_d = ovf_q | add_ovf;
            if (in_last_i) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    in_ready_d  = (state_d != DONE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_acc_o   = acc_q;
  assign out_cnt_o   = cnt_q;
  assign out_ovf_o   = ovf_q;

endmodule

// File: tb/tb_mul_acc_sgn.sv
// Self-checking bench for mul_acc_sgn: a 24-bit and a 17-bit accumulator
// share one stimulus stream and are compared against an integer model.
module tb_mul_acc_sgn;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_prod = '0;

  logic        in_ready, out_valid, out_ovf;
  logic [23:0] out_acc;
  logic [7:0]  out_cnt;
  logic        n_in_ready, n_out_valid, n_out_ovf;
  logic [16:0] n_out_acc;
  logic [7:0]  n_out_cnt;

  int total = 0;
  int bad = 0;

  logic [15:0] pkt[0:299];
  int          pkt_len = 0;

`ifdef MUL_ACC_SAT_EN
  localparam logic [16:0] OVF17_EXP = 17'h0FFFF;
`else
  localparam logic [16:0] OVF17_EXP = 17'h17FFD;
`endif

  always #5 clk = ~clk;

  mul_acc_sgn #(.widthP(16), .widthA(24), .widthC(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_prod_i(in_prod), .in_last_i(in_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_acc_o(out_acc), .out_cnt_o(out_cnt), .out_ovf_o(out_ovf)
  );

  mul_acc_sgn #(.widthP(16), .widthA(17), .widthC(8)) dut17 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
    .in_valid_i(in_valid), .in_ready_o(n_in_ready), .in_prod_i(in_prod), .in_last_i(in_last),
    .out_valid_o(n_out_valid), .out_ready_i(out_ready),
    .out_acc_o(n_out_acc), .out_cnt_o(n_out_cnt), .out_ovf_o(n_out_ovf)
  );

  // Reference: exact integer sum of the packet, range-checked per term.
  function automatic void model(input int w, output logic [23:0] acc_bits,
                                output logic [7:0] cnt, output logic ovf);
    longint maxv, minv, acc, s, p;
    maxv = (longint'(1) << (w - 1)) - 1;
    minv = -maxv - 1;
    acc  = 0;
    ovf  = 1'b0;
    for (int i = 0; i < pkt_len; i++) begin
      p = longint'($signed(pkt[i]));
      if (i == 0) begin
        acc = p;
      end else begin
        s = acc + p;
        if (s > maxv || s < minv) begin
          ovf = 1'b1;
`ifdef MUL_ACC_SAT_EN
          acc = (s > maxv) ? maxv : minv;
`else
          acc = (s > maxv) ? s - (longint'(1) << w) : s + (longint'(1) << w);
`endif
        end else begin
          acc = s;
        end
      end
    end
    acc_bits = acc[23:0];
    cnt      = (pkt_len > 255) ? 8'd255 : 8'(pkt_len);
  endfunction

  task automatic drive_beat(input logic [15:0] p, input logic last);
    int waits;
    waits    = 0;
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = last;
    while (in_ready !== 1'b1 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 20) begin
      total++; bad++;
      $display("[TB] FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic send_packet(input bit gaps);
    for (int i = 0; i < pkt_len; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_prod  = 16'($urandom);
        @(negedge clk);
      end
      drive_beat(pkt[i], (i == pkt_len - 1));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    total += 5;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b want 1", in_ready); end
    if (out_acc !== 24'h0) begin bad++; $display("[TB] FAIL reset_acc: got %h want 0", out_acc); end
    if (out_cnt !== 8'h0) begin bad++; $display("[TB] FAIL reset_cnt: got %0d want 0", out_cnt); end
    if (out_ovf !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf: got %b want 0", out_ovf); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    pkt_len = 2; pkt[0] = 16'h0006; pkt[1] = 16'hFFFD;
    send_packet(1'b0);
    total += 4;
    if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL basic_valid: got %b want 1", out_valid); end
    if (out_acc !== 24'h000003) begin bad++; $display("[TB] FAIL basic_acc: got %h want 000003", out_acc); end
    if (out_cnt !== 8'd2) begin bad++; $display("[TB] FAIL basic_cnt: got %0d want 2", out_cnt); end
    if (out_ovf !== 1'b0) begin bad++; $display("[TB] FAIL basic_ovf: got %b want 0", out_ovf); end
    @(negedge clk);
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_consume: got %b want 0", out_valid); end
    if (out_acc !== 24'h0) begin bad++; $display("[TB] FAIL basic_clear: got %h want 0", out_acc); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    pkt_len = 1; pkt[0] = 16'h8000;
    send_packet(1'b0);
    total += 4;
    if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid: got %b want 1", out_valid); end
    if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL single_ready: got %b want 0", in_ready); end
    if (out_acc !== 24'hFF8000) begin bad++; $display("[TB] FAIL single_acc: got %h want ff8000", out_acc); end
    if (out_cnt !== 8'd1) begin bad++; $display("[TB] FAIL single_cnt: got %0d want 1", out_cnt); end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    pkt_len = 3; pkt[0] = 16'h7FFF; pkt[1] = 16'h7FFF; pkt[2] = 16'h7FFF;
    send_packet(1'b0);
    total += 4;
    if (n_out_acc !== OVF17_EXP) begin bad++; $display("[TB] FAIL ovf17_acc: got %h want %h", n_out_acc, OVF17_EXP); end
    if (n_out_ovf !== 1'b1) begin bad++; $display("[TB] FAIL ovf17_flag: got %b want 1", n_out_ovf); end
    if (out_acc !== 24'h017FFD) begin bad++; $display("[TB] FAIL ovf24_acc: got %h want 017ffd", out_acc); end
    if (out_ovf !== 1'b0) begin bad++; $display("[TB] FAIL ovf24_flag: got %b want 0", out_ovf); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [23:0] ea;
    logic [7:0]  ec;
    logic        eo;
    out_ready = 1'b0;
    pkt_len = 3;
    for (int i = 0; i < 3; i++) pkt[i] = 16'($urandom);
    model(24, ea, ec, eo);
    send_packet(1'b1);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_prod = 16'h0123; in_last = 1'b1;
      total += 5;
      if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid[%0d]: got %b want 1", k, out_valid); end
      if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready[%0d]: got %b want 0", k, in_ready); end
      if (out_acc !== ea) begin bad++; $display("[TB] FAIL bp_acc[%0d]: got %h want %h", k, out_acc, ea); end
      if (out_cnt !== ec) begin bad++; $display("[TB] FAIL bp_cnt[%0d]: got %0d want %0d", k, out_cnt, ec); end
      if (out_ovf !== eo) begin bad++; $display("[TB] FAIL bp_ovf[%0d]: got %b want %b", k, out_ovf, eo); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    total += 3;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_release_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_ready: got %b want 1", in_ready); end
    if (out_cnt !== 8'd0) begin bad++; $display("[TB] FAIL bp_no_accept: cnt got %0d want 0", out_cnt); end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    total += 3;
    if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_next_valid: got %b want 1", out_valid); end
    if (out_acc !== 24'h000123) begin bad++; $display("[TB] FAIL bp_next_acc: got %h want 000123", out_acc); end
    if (out_cnt !== 8'd1) begin bad++; $display("[TB] FAIL bp_next_cnt: got %0d want 1", out_cnt); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [23:0] ea, ea17;
    logic [7:0]  ec, ec17;
    logic        eo, eo17;
    int          d;
    for (int n = 0; n < 25; n++) begin
      out_ready = 1'b0;
      pkt_len = $urandom_range(1, 6);
      for (int i = 0; i < pkt_len; i++) begin
        case ($urandom_range(0, 3))
          0: pkt[i] = 16'h7FFF;
          1: pkt[i] = 16'h8000;
          default: pkt[i] = 16'($urandom);
        endcase
      end
      model(24, ea, ec, eo);
      model(17, ea17, ec17, eo17);
      send_packet(1'b1);
      d = $urandom_range(0, 2);
      for (int k = 0; k <= d; k++) begin
        total += 7;
        if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL rnd%0d_valid: got %b want 1", n, out_valid); end
        if (out_acc !== ea) begin bad++; $display("[TB] FAIL rnd%0d_acc: got %h want %h", n, out_acc, ea); end
        if (out_cnt !== ec) begin bad++; $display("[TB] FAIL rnd%0d_cnt: got %0d want %0d", n, out_cnt, ec); end
        if (out_ovf !== eo) begin bad++; $display("[TB] FAIL rnd%0d_ovf: got %b want %b", n, out_ovf, eo); end
        if (n_in_ready !== 1'b0) begin bad++; $display("[TB] FAIL rnd%0d_n_ready: got %b want 0", n, n_in_ready); end
        if (n_out_acc !== ea17[16:0]) begin bad++; $display("[TB] FAIL rnd%0d_n_acc: got %h want %h", n, n_out_acc, ea17[16:0]); end
        if (n_out_ovf !== eo17) begin bad++; $display("[TB] FAIL rnd%0d_n_ovf: got %b want %b", n, n_out_ovf, eo17); end
        if (k == d) out_ready = 1'b1;
        @(negedge clk);
      end
      out_ready = 1'b0;
      total += 2;
      if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rnd%0d_consume: got %b want 0", n, out_valid); end
      if (n_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rnd%0d_n_consume: got %b want 0", n, n_out_valid); end
    end
  endtask

  task automatic test_cnt_sat();
    out_ready = 1'b1;
    pkt_len = 260;
    for (int i = 0; i < 260; i++) pkt[i] = 16'h0001;
    send_packet(1'b0);
    total += 3;
    if (out_cnt !== 8'd255) begin bad++; $display("[TB] FAIL cnt_sat: got %0d want 255", out_cnt); end
    if (out_acc !== 24'd260) begin bad++; $display("[TB] FAIL cnt_sat_acc: got %0d want 260", out_acc); end
    if (out_ovf !== 1'b0) begin bad++; $display("[TB] FAIL cnt_sat_ovf: got %b want 0", out_ovf); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    out_ready = 1'b1;
    drive_beat(16'h0010, 1'b0);
    drive_beat(16'h0020, 1'b0);
    total += 2;
    if (out_acc !== 24'h000030) begin bad++; $display("[TB] FAIL abort_partial_acc: got %h want 000030", out_acc); end
    if (out_cnt !== 8'd2) begin bad++; $display("[TB] FAIL abort_partial_cnt: got %0d want 2", out_cnt); end
    clr = 1'b1; in_valid = 1'b1; in_prod = 16'h1234; in_last = 1'b0;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    total += 3;
    if (out_acc !== 24'h0) begin bad++; $display("[TB] FAIL abort_acc: got %h want 0", out_acc); end
    if (out_cnt !== 8'd0) begin bad++; $display("[TB] FAIL abort_cnt: got %0d want 0", out_cnt); end
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL abort_ready: got %b want 1", in_ready); end
    pkt_len = 2; pkt[0] = 16'h0005; pkt[1] = 16'h0007;
    send_packet(1'b0);
    total += 2;
    if (out_acc !== 24'd12) begin bad++; $display("[TB] FAIL abort_next_acc: got %h want 00000c", out_acc); end
    if (out_cnt !== 8'd2) begin bad++; $display("[TB] FAIL abort_next_cnt: got %0d want 2", out_cnt); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive_beat(16'h0100, 1'b0);
    drive_beat(16'h0200, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total += 4;
    if (out_acc !== 24'h0) begin bad++; $display("[TB] FAIL rstmid_acc: got %h want 0", out_acc); end
    if (out_cnt !== 8'd0) begin bad++; $display("[TB] FAIL rstmid_cnt: got %0d want 0", out_cnt); end
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pkt_len = 2; pkt[0] = 16'h0003; pkt[1] = 16'h0004;
    send_packet(1'b0);
    total += 2;
    if (out_acc !== 24'd7) begin bad++; $display("[TB] FAIL rstmid_next_acc: got %h want 000007", out_acc); end
    if (out_cnt !== 8'd2) begin bad++; $display("[TB] FAIL rstmid_next_cnt: got %0d want 2", out_cnt); end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_overflow();
    test_backpressure();
    test_random();
    test_cnt_sat();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
